ramb_arbiter: RTL and testbench

- Two-requester access controller for one SB_RAM40_4K configured 256x16 (READ_MODE=0, WRITE_MODE=0).
- After reset, a built-in clear sequencer writes zero to every word. The block then grants each RAM port (read, write) to requester A or B using per-port round-robin.
- A read and a write can be granted in the same cycle when they come from different requesters.
- Sits between user logic and the RAM primitive; drives all RAM control pins.

---
 rtl/ramb_arbiter.sv | 136 +++++++++++++
 tb/tb_ramb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ramb_arbiter.sv
// Two-requester access controller for a 256x16 block RAM: clears the RAM after
// reset, then arbitrates the read and write ports independently with round-robin.

module ramb_arbiter_rr (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    logic ptr_q, ptr_d;  // 0 favours A, 1 favours B on contention

    always_comb begin
        gnt_a = req_a & (~req_b | ~ptr_q);
        gnt_b = req_b & (~req_a |  ptr_q);
        ptr_d = ptr_q;
        if (req_a && req_b) ptr_d = ~ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
endmodule

module ramb_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLKIN,
    input  logic                  RESETN,
    input  logic                  A_VALID,
    input  logic                  A_WRITE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_WDATA,
    output logic                  A_READY,
    output logic                  A_RVALID,
    output logic [DATA_WIDTH-1:0] A_RDATA,
    input  logic                  B_VALID,
    input  logic                  B_WRITE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_WDATA,
    output logic                  B_READY,
    output logic                  B_RVALID,
    output logic [DATA_WIDTH-1:0] B_RDATA,
    output logic                  INIT_DONE,
    output logic [ADDR_WIDTH-1:0] RADDR,
    output logic                  RE,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic [ADDR_WIDTH-1:0] WADDR,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WE,
    output logic [DATA_WIDTH-1:0] MASK
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic                  run;
    // Index 0 is the read port, index 1 the write port.
    logic [1:0]            req_a, req_b, gnt_a, gnt_b;

    assign run      = (state_q == S_RUN);
    assign req_a[0] = run & A_VALID & ~A_WRITE;
    assign req_b[0] = run & B_VALID & ~B_WRITE;
    assign req_a[1] = run & A_VALID &  A_WRITE;
    assign req_b[1] = run & B_VALID &  B_WRITE;

    for (genvar p = 0; p < 2; p++) begin : g_port
        ramb_arbiter_rr u_rr (
            .clk   (CLKIN),
            .rst_n (RESETN),
            .req_a (req_a[p]),
            .req_b (req_b[p]),
            .gnt_a (gnt_a[p]),
            .gnt_b (gnt_b[p])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_rvalid_d = gnt_a[0];
        b_rvalid_d = gnt_b[0];
        A_READY    = 1'b0;
        B_READY    = 1'b0;
        RE         = 1'b0;
        RADDR      = '0;
        WE         = 1'b0;
        WADDR      = '0;
        WDATA      = '0;
        case (state_q)
            S_INIT: begin
                // Gate on RESETN so the RAM sees no write while reset is held.
                WE    = RESETN;
                WADDR = cnt_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_RUN;
            end
            S_RUN: begin
                A_READY = gnt_a[0] | gnt_a[1];
                B_READY = gnt_b[0] | gnt_b[1];
                RE      = gnt_a[0] | gnt_b[0];
                RADDR   = gnt_a[0] ? A_ADDR : (gnt_b[0] ? B_ADDR : '0);
                WE      = gnt_a[1] | gnt_b[1];
                WADDR   = gnt_a[1] ? A_ADDR : (gnt_b[1] ? B_ADDR : '0);
                WDATA   = gnt_a[1] ? A_WDATA : (gnt_b[1] ? B_WDATA : '0);
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    assign A_RVALID  = a_rvalid_q;
    assign B_RVALID  = b_rvalid_q;
    assign A_RDATA   = a_rvalid_q ? RDATA : '0;
    assign B_RDATA   = b_rvalid_q ? RDATA : '0;
    assign INIT_DONE = run;
    assign MASK      = '0;
endmodule

// File: tb/tb_ramb_arbiter.sv
// Bench for ramb_arbiter: behavioural RAM plus a reference model that predicts
// grants, RAM pins and read responses from the arbitration rules.

module tb_ramb_arbiter;
    localparam int DEPTH = 256;

    logic        CLKIN, RESETN;
    logic        A_VALID, A_WRITE, B_VALID, B_WRITE;
    logic [7:0]  A_ADDR, B_ADDR;
    logic [15:0] A_WDATA, B_WDATA;
    logic        A_READY, A_RVALID, B_READY, B_RVALID;
    logic [15:0] A_RDATA, B_RDATA;
    logic        INIT_DONE, RE, WE;
    logic [7:0]  RADDR, WADDR;
    logic [15:0] RDATA, WDATA, MASK;

    ramb_arbiter dut (
        .CLKIN(CLKIN), .RESETN(RESETN),
        .A_VALID(A_VALID), .A_WRITE(A_WRITE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_READY(A_READY), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
        .B_VALID(B_VALID), .B_WRITE(B_WRITE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_READY(B_READY), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
        .INIT_DONE(INIT_DONE), .RADDR(RADDR), .RE(RE), .RDATA(RDATA),
        .WADDR(WADDR), .WDATA(WDATA), .WE(WE), .MASK(MASK)
    );

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    // Block RAM with synchronous read (old data on same-address write)
    logic [15:0] ram_mem [DEPTH];
    always @(posedge CLKIN) begin
        if (WE) ram_mem[WADDR] <= (ram_mem[WADDR] & MASK) | (WDATA & ~MASK);
        if (RE) RDATA <= ram_mem[RADDR];
    end

    // Reference model state
    logic [15:0] ref_mem [DEPTH];
    int          cyc, rd_cont, wr_cont;
    bit          exp_rv_a, exp_rv_b;
    logic [15:0] exp_rd_a, exp_rd_b;
    int          checks, failures;
    bit          acc_a, acc_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input bit v, input bit w, input logic [7:0] ad, input logic [15:0] d);
        A_VALID = v; A_WRITE = w; A_ADDR = ad; A_WDATA = d;
    endtask

    task automatic set_b(input bit v, input bit w, input logic [7:0] ad, input logic [15:0] d);
        B_VALID = v; B_WRITE = w; B_ADDR = ad; B_WDATA = d;
    endtask

    // One clock: predict, check, advance. Called at posedge+1 with inputs set.
    task automatic tick(output bit ga, output bit gb);
        bit in_run, ra, rb, wa, wb, gra, grb, gwa, gwb;
        in_run = (cyc >= DEPTH);
        ra = in_run && A_VALID && !A_WRITE;
        rb = in_run && B_VALID && !B_WRITE;
        wa = in_run && A_VALID &&  A_WRITE;
        wb = in_run && B_VALID &&  B_WRITE;
        // Contested grants alternate starting with A: even count -> A wins.
        if (ra && rb) begin gra = (rd_cont % 2 == 0); grb = !gra; rd_cont++; end
        else begin gra = ra; grb = rb; end
        if (wa && wb) begin gwa = (wr_cont % 2 == 0); gwb = !gwa; wr_cont++; end
        else begin gwa = wa; gwb = wb; end
        #2;
        chk("init_done", 32'(INIT_DONE), 32'(in_run));
        chk("a_ready", 32'(A_READY), 32'(gra | gwa));
        chk("b_ready", 32'(B_READY), 32'(grb | gwb));
        chk("mask", 32'(MASK), 32'h0);
        chk("re", 32'(RE), 32'(gra | grb));
        if (gra | grb) chk("raddr", 32'(RADDR), 32'(gra ? A_ADDR : B_ADDR));
        if (!in_run) begin
            chk("init_we", 32'(WE), 32'h1);
            chk("init_waddr", 32'(WADDR), 32'(cyc));
            chk("init_wdata", 32'(WDATA), 32'h0);
        end else begin
            chk("we", 32'(WE), 32'(gwa | gwb));
            if (gwa | gwb) begin
                chk("waddr", 32'(WADDR), 32'(gwa ? A_ADDR : B_ADDR));
                chk("wdata", 32'(WDATA), 32'(gwa ? A_WDATA : B_WDATA));
            end
        end
        chk("a_rvalid", 32'(A_RVALID), 32'(exp_rv_a));
        if (exp_rv_a) chk("a_rdata", 32'(A_RDATA), 32'(exp_rd_a));
        chk("b_rvalid", 32'(B_RVALID), 32'(exp_rv_b));
        if (exp_rv_b) chk("b_rdata", 32'(B_RDATA), 32'(exp_rd_b));
        // Reads see memory before this cycle's write.
        exp_rv_a = gra; exp_rd_a = ref_mem[A_ADDR];
        exp_rv_b = grb; exp_rd_b = ref_mem[B_ADDR];
        if (!in_run) ref_mem[cyc] = 16'h0;
        else if (gwa) ref_mem[A_ADDR] = A_WDATA;
        else if (gwb) ref_mem[B_ADDR] = B_WDATA;
        ga = gra | gwa;
        gb = grb | gwb;
        @(posedge CLKIN); #1;
        cyc++;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        #2;
        chk("rst_a_ready", 32'(A_READY), 32'h0);
        chk("rst_b_ready", 32'(B_READY), 32'h0);
        chk("rst_a_rvalid", 32'(A_RVALID), 32'h0);
        chk("rst_b_rvalid", 32'(B_RVALID), 32'h0);
        chk("rst_init_done", 32'(INIT_DONE), 32'h0);
        chk("rst_re_we", 32'({RE, WE}), 32'h0);
        chk("rst_addr", 32'({RADDR, WADDR, WDATA}), 32'h0);
        @(posedge CLKIN); #1;
        RESETN = 1'b1;
        cyc = 0; rd_cont = 0; wr_cont = 0;
        exp_rv_a = 0; exp_rv_b = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(acc_a, acc_b);
    endtask

    initial begin
        checks = 0; failures = 0;
        RESETN = 1'b0;
        set_a(0, 0, 8'h0, 16'h0);
        set_b(0, 0, 8'h0, 16'h0);
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 16'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        #1;
        do_reset();

        // Full clear, then a read of a cleared word.
        idle(DEPTH);
        set_a(1, 0, 8'h7F, 16'h0); tick(acc_a, acc_b);
        set_a(0, 0, 8'h0, 16'h0);  idle(1);

        // Write then read back.
        set_a(1, 1, 8'hA5, 16'h1234); tick(acc_a, acc_b);
        set_a(1, 0, 8'hA5, 16'h0);    tick(acc_a, acc_b);
        set_a(0, 0, 8'h0, 16'h0);     idle(1);

        // Preload and contend reads continuously.
        set_a(1, 1, 8'h01, 16'h1111); tick(acc_a, acc_b);
        set_a(1, 1, 8'h02, 16'h2222); tick(acc_a, acc_b);
        set_a(1, 0, 8'h01, 16'h0);
        set_b(1, 0, 8'h02, 16'h0);
        idle(6);
        set_a(0, 0, 8'h0, 16'h0); set_b(0, 0, 8'h0, 16'h0); idle(1);

        // Concurrent write (A) and read (B) of the same word.
        set_a(1, 1, 8'h10, 16'hBEEF);
        set_b(1, 0, 8'h10, 16'h0);
        tick(acc_a, acc_b);
        set_a(0, 0, 8'h0, 16'h0);
        tick(acc_a, acc_b);
        set_b(0, 0, 8'h0, 16'h0); idle(1);

        // Contended writes: A first, B next; B's data survives.
        set_a(1, 1, 8'h20, 16'hAAAA);
        set_b(1, 1, 8'h20, 16'hBBBB);
        tick(acc_a, acc_b);
        set_a(0, 0, 8'h0, 16'h0); tick(acc_a, acc_b);
        set_b(0, 0, 8'h0, 16'h0);
        set_a(1, 0, 8'h20, 16'h0); tick(acc_a, acc_b);
        set_a(0, 0, 8'h0, 16'h0);  idle(1);

        // Randomized traffic over a small address window.
        acc_a = 1; acc_b = 1;
        for (int i = 0; i < 400; i++) begin
            if (!A_VALID || acc_a) begin
                if ($urandom_range(9) < 7)
                    set_a(1, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom));
                else A_VALID = 1'b0;
            end else if ($urandom_range(19) == 0) A_VALID = 1'b0;
            if (!B_VALID || acc_b) begin
                if ($urandom_range(9) < 7)
                    set_b(1, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom));
                else B_VALID = 1'b0;
            end else if ($urandom_range(19) == 0) B_VALID = 1'b0;
            tick(acc_a, acc_b);
        end
        set_a(0, 0, 8'h0, 16'h0); set_b(0, 0, 8'h0, 16'h0); idle(2);

        // Reset mid-clear restarts at address 0.
        do_reset();
        idle(100);
        do_reset();
        idle(DEPTH);

        // Contended read (A wins, pointer moves to B), then reset under the response.
        set_a(1, 0, 8'h01, 16'h0);
        set_b(1, 0, 8'h02, 16'h0);
        tick(acc_a, acc_b);
        set_a(0, 0, 8'h0, 16'h0); set_b(0, 0, 8'h0, 16'h0);
        do_reset();
        idle(DEPTH);

        // Pointer is back at A after reset.
        set_a(1, 0, 8'h03, 16'h0);
        set_b(1, 0, 8'h04, 16'h0);
        tick(acc_a, acc_b);
        set_a(0, 0, 8'h0, 16'h0);
        tick(acc_a, acc_b);
        set_b(0, 0, 8'h0, 16'h0); idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
